// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
//   fetch_state_t  : fetch FSM state encoding (StIdle / StFetch / StDrain)
//   fetch_entry_t  : queue entry, {pc, word}
//   INSTR_BYTES    : instruction size in bytes, used as the PC step
//   word_align()   : clears the byte-offset bits of an address
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t StIdle  = 2'd0;
  localparam fetch_state_t StFetch = 2'd1;
  localparam fetch_state_t StDrain = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous in-order FIFO of fetch entries.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : empties the FIFO; wins over push/pop in the same cycle
//   push_i/wdata_i: write one entry (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   rdata_o       : head entry
//   full_o/empty_o/count_o : status and occupancy
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           wdata_i,
  input  logic                   pop_i,
  output fetch_entry_t           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Depth is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: runs the fetch PC, issues word-aligned reads to a
// variable-latency instruction memory, buffers returned words tagged with
// their PC and hands them to decode over valid/ready. A redirect flushes the
// queue and discards the responses still in flight.
//   clk, resetN            : clock, asynchronous active-low reset
//   memReq/memAddr/memGnt  : read request channel (committed on memGnt)
//   memRValid/memRData     : in-order read responses
//   instrValid/instr/instrPC/instrReady : decode handshake
//   redirect/redirectPC    : taken branch/jump, new fetch address
// Optional macro FETCH_BYPASS_EN: an empty queue forwards a response straight
// to decode in the same cycle instead of registering it first.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetN,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memGnt,
  input  logic        memRValid,
  input  logic [31:0] memRData,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [31:0] instrPC,
  input  logic        instrReady,
  input  logic        redirect,
  input  logic [31:0] redirectPC
);

  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam logic [31:0] PcStep = 32'(INSTR_BYTES);

  fetch_state_t    state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

  fetch_entry_t    fifo_head, fifo_wdata;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;

  logic            grant, resp_cnt, dropping, resp_keep;
  logic [CntW-1:0] remaining;
  logic [CntW:0]   credit_used;

  assign grant = memReq & memGnt;
  // Stray responses with nothing outstanding must not underflow the counter.
  assign resp_cnt    = memRValid & (outstanding_q != '0);
  assign remaining   = outstanding_q - CntW'(resp_cnt);
  assign dropping    = (drop_cnt_q != '0);
  assign resp_keep   = memRValid & ~dropping & ~redirect;
  // Queue slots plus in-flight requests never exceed DEPTH, so no overflow.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};

  assign memReq  = (state_q == StFetch) & ~redirect & ~fifo_full &
                   (credit_used < (CntW + 1)'(DEPTH));
  assign memAddr = fetch_pc_q;

  assign fifo_wdata = '{pc: resp_pc_q, word: memRData};
  // Decode's pop in a redirect cycle is discarded along with the queue.
  assign fifo_pop   = instrReady & ~fifo_empty & ~redirect;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass     = resp_keep & fifo_empty;
  assign instrValid = ~fifo_empty | bypass;
  assign instr      = bypass ? memRData : fifo_head.word;
  assign instrPC    = bypass ? resp_pc_q : fifo_head.pc;
  assign fifo_push  = resp_keep & ~(bypass & instrReady);
`else
  assign instrValid = ~fifo_empty;
  assign instr      = fifo_head.word;
  assign instrPC    = fifo_head.pc;
  assign fifo_push  = resp_keep;
`endif

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CntW'(grant) - CntW'(resp_cnt);

    if (grant) fetch_pc_d = fetch_pc_q + PcStep;

    if (redirect) begin
      fetch_pc_d = word_align(redirectPC);
      resp_pc_d  = word_align(redirectPC);
      drop_cnt_d = remaining;
    end else if (memRValid) begin
      if (dropping) drop_cnt_d = drop_cnt_q - 1'b1;
      else          resp_pc_d  = resp_pc_q + PcStep;
    end

    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (redirect && (remaining != '0)) state_d = StDrain;
      StDrain: if (!redirect && (drop_cnt_d == '0)) state_d = StFetch;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= StIdle;
      fetch_pc_q    <= word_align(RESET_PC);
      resp_pc_q     <= word_align(RESET_PC);
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (resetN),
    .flush_i (redirect),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule
